// File: rtl/sobel_addr_gen.sv
// Address sequencer for the Sobel pipeline: raster-order linear scan or
// 3x3 neighbourhood scan of every interior pixel, over a valid/ready port.
module sobel_addr_gen #(
   parameter int IMG_W  = 32,
   parameter int IMG_H  = 32,
   parameter int ADDR_W = 10,
   parameter int CRD_W  = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              mode,
   input  logic              abort,
   output logic              addr_valid,
   input  logic              addr_ready,
   output logic [ADDR_W-1:0] addr,
   output logic [3:0]        tap_idx,
   output logic [CRD_W-1:0]  center_x,
   output logic [CRD_W-1:0]  center_y,
   output logic              win_last,
   output logic              last,
   output logic              busy,
   output logic              done
);

   localparam int AW1 = ADDR_W + 1;
   localparam logic [AW1-1:0]   ROW_STEP  = AW1'(IMG_W);
   localparam logic [AW1-1:0]   COL_ONE   = AW1'(1);
   localparam logic [CRD_W-1:0] CRD_ONE   = CRD_W'(1);
   localparam logic [CRD_W-1:0] X_LIN_MAX = CRD_W'(IMG_W - 1);
   localparam logic [CRD_W-1:0] Y_LIN_MAX = CRD_W'(IMG_H - 1);
   localparam logic [CRD_W-1:0] X_WIN_MAX = CRD_W'(IMG_W - 2);
   localparam logic [CRD_W-1:0] Y_WIN_MAX = CRD_W'(IMG_H - 2);

   typedef enum logic [1:0] {
      IDLE,
      LINEAR,
      WINDOW,
      FIN
   } state_t;

   state_t           state_q, state_d;
   logic [CRD_W-1:0] x_q, x_d;
   logic [CRD_W-1:0] y_q, y_d;
   logic [3:0]       tap_q, tap_d;
   // row_base tracks y*IMG_W; win_row tracks (y+dy)*IMG_W for the current tap
   logic [AW1-1:0]   row_base_q, row_base_d;
   logic [AW1-1:0]   win_row_q, win_row_d;

   logic             fire;
   logic             clr;
   logic             tap_end;
   logic             lin_end;
   logic             win_end;
   logic [AW1-1:0]   col;
   logic [AW1-1:0]   base;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         x_q        <= '0;
         y_q        <= '0;
         tap_q      <= '0;
         row_base_q <= '0;
         win_row_q  <= '0;
      end else begin
         state_q    <= state_d;
         x_q        <= x_d;
         y_q        <= y_d;
         tap_q      <= tap_d;
         row_base_q <= row_base_d;
         win_row_q  <= win_row_d;
      end
   end

   assign busy    = (state_q == LINEAR) || (state_q == WINDOW);
   assign fire    = busy && addr_ready;
   assign tap_end = (tap_q == 4'd8);
   assign lin_end = (state_q == LINEAR) && (x_q == X_LIN_MAX) && (y_q == Y_LIN_MAX);
   assign win_end = (state_q == WINDOW) && tap_end && (x_q == X_WIN_MAX) && (y_q == Y_WIN_MAX);

   always_comb begin
      state_d    = state_q;
      x_d        = x_q;
      y_d        = y_q;
      tap_d      = tap_q;
      row_base_d = row_base_q;
      win_row_d  = win_row_q;
      clr        = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               tap_d = '0;
               if (mode) begin
                  state_d    = WINDOW;
                  x_d        = CRD_ONE;
                  y_d        = CRD_ONE;
                  row_base_d = ROW_STEP;
                  win_row_d  = '0;
               end else begin
                  state_d    = LINEAR;
                  x_d        = '0;
                  y_d        = '0;
                  row_base_d = '0;
                  win_row_d  = '0;
               end
            end
         end
         LINEAR: begin
            if (abort) begin
               state_d = IDLE;
               clr     = 1'b1;
            end else if (fire) begin
               if (lin_end) begin
                  state_d = FIN;
                  clr     = 1'b1;
               end else if (x_q == X_LIN_MAX) begin
                  x_d        = '0;
                  y_d        = y_q + CRD_ONE;
                  row_base_d = row_base_q + ROW_STEP;
               end else begin
                  x_d = x_q + CRD_ONE;
               end
            end
         end
         WINDOW: begin
            if (abort) begin
               state_d = IDLE;
               clr     = 1'b1;
            end else if (fire) begin
               if (win_end) begin
                  state_d = FIN;
                  clr     = 1'b1;
               end else if (tap_end) begin
                  tap_d = '0;
                  if (x_q == X_WIN_MAX) begin
                     // the old centre row becomes the top tap row of the next centre row
                     x_d        = CRD_ONE;
                     y_d        = y_q + CRD_ONE;
                     row_base_d = row_base_q + ROW_STEP;
                     win_row_d  = row_base_q;
                  end else begin
                     x_d       = x_q + CRD_ONE;
                     win_row_d = row_base_q - ROW_STEP;
                  end
               end else begin
                  tap_d = tap_q + 4'd1;
                  if (tap_q == 4'd2 || tap_q == 4'd5) begin
                     win_row_d = win_row_q + ROW_STEP;
                  end
               end
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (clr) begin
         x_d        = '0;
         y_d        = '0;
         tap_d      = '0;
         row_base_d = '0;
         win_row_d  = '0;
      end
   end

   always_comb begin
      col = AW1'(x_q);
      if (state_q == WINDOW) begin
         case (tap_q)
            4'd0, 4'd3, 4'd6: col = AW1'(x_q) - COL_ONE;
            4'd2, 4'd5, 4'd8: col = AW1'(x_q) + COL_ONE;
            default:          col = AW1'(x_q);
         endcase
      end
   end

   assign base       = (state_q == WINDOW) ? win_row_q : row_base_q;
   assign addr_valid = busy;
   assign addr       = busy ? ADDR_W'(base + col) : '0;
   assign tap_idx    = (state_q == WINDOW) ? tap_q : 4'd0;
   assign center_x   = busy ? x_q : '0;
   assign center_y   = busy ? y_q : '0;
   assign win_last   = (state_q == WINDOW) && tap_end;
   assign last       = lin_end || win_end;
   assign done       = (state_q == FIN);

endmodule

// File: tb/tb_sobel_addr_gen.sv
// Directed bench for sobel_addr_gen: default 32x32 instance plus a 5x3
// instance for the small-image window case.
module tb_sobel_addr_gen;

   logic       clk;
   logic       rst;
   logic       start;
   logic       mode;
   logic       abort;
   logic       addr_valid;
   logic       addr_ready;
   logic [9:0] addr;
   logic [3:0] tap_idx;
   logic [4:0] center_x;
   logic [4:0] center_y;
   logic       win_last;
   logic       last;
   logic       busy;
   logic       done;

   logic       s_start;
   logic       s_mode;
   logic       s_abort;
   logic       s_valid;
   logic       s_ready;
   logic [3:0] s_addr;
   logic [3:0] s_tap;
   logic [2:0] s_cx;
   logic [2:0] s_cy;
   logic       s_win_last;
   logic       s_last;
   logic       s_busy;
   logic       s_done;

   int assertions;
   int failures;

   sobel_addr_gen dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .mode       (mode),
      .abort      (abort),
      .addr_valid (addr_valid),
      .addr_ready (addr_ready),
      .addr       (addr),
      .tap_idx    (tap_idx),
      .center_x   (center_x),
      .center_y   (center_y),
      .win_last   (win_last),
      .last       (last),
      .busy       (busy),
      .done       (done)
   );

   sobel_addr_gen #(.IMG_W(5), .IMG_H(3), .ADDR_W(4), .CRD_W(3)) dut_small (
      .clk        (clk),
      .rst        (rst),
      .start      (s_start),
      .mode       (s_mode),
      .abort      (s_abort),
      .addr_valid (s_valid),
      .addr_ready (s_ready),
      .addr       (s_addr),
      .tap_idx    (s_tap),
      .center_x   (s_cx),
      .center_y   (s_cy),
      .win_last   (s_win_last),
      .last       (s_last),
      .busy       (s_busy),
      .done       (s_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference window address for the k-th accepted handshake of a w-wide image
   function automatic int win_addr(input int k, input int w);
      int c, t, cx, cy;
      c  = k / 9;
      t  = k % 9;
      cx = 1 + c % (w - 2);
      cy = 1 + c / (w - 2);
      return (cy + t / 3 - 1) * w + cx + t % 3 - 1;
   endfunction

   task automatic test_reset();
      rst   = 1'b1;
      start = 1'b1;
      mode  = 1'b1;
      repeat (3) begin
         @(negedge clk);
         #1;
         assertions++;
         if ({addr_valid, addr, tap_idx, center_x, center_y, win_last, last, busy, done} !== '0)
            begin failures++; $display("[TB] FAIL reset_outputs: got valid=%0b addr=%0d busy=%0b done=%0b, required all zero", addr_valid, addr, busy, done); end
      end
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;
      #1;
      assertions++;
      if (busy !== 1'b0 || addr_valid !== 1'b0)
         begin failures++; $display("[TB] FAIL reset_release: got busy=%0b valid=%0b, required 0 0", busy, addr_valid); end
   endtask

   task automatic test_linear();
      int hs, cyc;
      logic [9:0] ea;
      logic el;
      hs  = 0;
      cyc = 0;
      @(negedge clk);
      start = 1'b1; mode = 1'b0; addr_ready = 1'b1;
      while (hs < 1024 && cyc < 3000) begin
         @(negedge clk);
         start = 1'b0;
         #1;
         ea = 10'(hs);
         el = (hs == 1023);
         assertions++;
         if (addr_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0)
            begin failures++; $display("[TB] FAIL lin_flags at %0d: got valid=%0b busy=%0b done=%0b, required 1 1 0", hs, addr_valid, busy, done); end
         assertions++;
         if (addr !== ea)
            begin failures++; $display("[TB] FAIL lin_addr: got %0d, required %0d", addr, ea); end
         assertions++;
         if (center_x !== 5'(hs % 32) || center_y !== 5'(hs / 32))
            begin failures++; $display("[TB] FAIL lin_centre at %0d: got (%0d,%0d)", hs, center_x, center_y); end
         assertions++;
         if (last !== el || tap_idx !== 4'd0 || win_last !== 1'b0)
            begin failures++; $display("[TB] FAIL lin_last at %0d: got last=%0b tap=%0d wl=%0b, required last=%0b", hs, last, tap_idx, win_last, el); end
         if (addr_valid && addr_ready) hs++;
         cyc++;
      end
      assertions++;
      if (hs != 1024)
         begin failures++; $display("[TB] FAIL lin_timeout: got %0d handshakes, required 1024", hs); end
      @(negedge clk);
      start = 1'b1; mode = 1'b0;
      #1;
      assertions++;
      if (done !== 1'b1 || addr_valid !== 1'b0 || busy !== 1'b0)
         begin failures++; $display("[TB] FAIL lin_done: got done=%0b valid=%0b busy=%0b, required 1 0 0", done, addr_valid, busy); end
      @(negedge clk);
      start = 1'b0;
      #1;
      assertions++;
      if (done !== 1'b0 || busy !== 1'b0 || addr_valid !== 1'b0)
         begin failures++; $display("[TB] FAIL lin_after_done: got done=%0b busy=%0b valid=%0b, required 0 0 0", done, busy, addr_valid); end
   endtask

   task automatic test_window();
      int hs, cyc;
      int first9[9];
      int last9[9];
      logic [9:0] ea;
      first9 = '{0, 1, 2, 32, 33, 34, 64, 65, 66};
      last9  = '{957, 958, 959, 989, 990, 991, 1021, 1022, 1023};
      hs  = 0;
      cyc = 0;
      @(negedge clk);
      start = 1'b1; mode = 1'b1; addr_ready = 1'b1;
      while (hs < 8100 && cyc < 9000) begin
         @(negedge clk);
         start = 1'b0;
         #1;
         ea = 10'(win_addr(hs, 32));
         assertions++;
         if (addr_valid !== 1'b1 || done !== 1'b0)
            begin failures++; $display("[TB] FAIL win_bubble at %0d: got valid=%0b done=%0b", hs, addr_valid, done); end
         assertions++;
         if (addr !== ea || tap_idx !== 4'(hs % 9))
            begin failures++; $display("[TB] FAIL win_addr at %0d: got addr=%0d tap=%0d, required addr=%0d tap=%0d", hs, addr, tap_idx, ea, hs % 9); end
         assertions++;
         if (center_x !== 5'(1 + (hs / 9) % 30) || center_y !== 5'(1 + (hs / 9) / 30))
            begin failures++; $display("[TB] FAIL win_centre at %0d: got (%0d,%0d)", hs, center_x, center_y); end
         assertions++;
         if (win_last !== (hs % 9 == 8) || last !== (hs == 8099))
            begin failures++; $display("[TB] FAIL win_flags at %0d: got wl=%0b last=%0b", hs, win_last, last); end
         if (hs < 9) begin
            assertions++;
            if (addr !== 10'(first9[hs]) || center_x !== 5'd1 || center_y !== 5'd1)
               begin failures++; $display("[TB] FAIL win_first9 at %0d: got %0d, required %0d", hs, addr, first9[hs]); end
         end
         if (hs == 9) begin
            assertions++;
            if (addr !== 10'd1 || center_x !== 5'd2 || center_y !== 5'd1)
               begin failures++; $display("[TB] FAIL win_centre2: got addr=%0d centre=(%0d,%0d), required 1 (2,1)", addr, center_x, center_y); end
         end
         if (hs >= 8091) begin
            assertions++;
            if (addr !== 10'(last9[hs - 8091]))
               begin failures++; $display("[TB] FAIL win_last9 at %0d: got %0d, required %0d", hs, addr, last9[hs - 8091]); end
         end
         if (addr_valid && addr_ready) hs++;
         cyc++;
      end
      assertions++;
      if (hs != 8100)
         begin failures++; $display("[TB] FAIL win_timeout: got %0d handshakes, required 8100", hs); end
      @(negedge clk);
      #1;
      assertions++;
      if (done !== 1'b1 || addr_valid !== 1'b0)
         begin failures++; $display("[TB] FAIL win_done: got done=%0b valid=%0b, required 1 0", done, addr_valid); end
   endtask

   task automatic test_backpressure();
      int hs, cyc;
      logic stalled;
      logic [9:0] h_addr;
      logic [3:0] h_tap;
      logic [4:0] h_cx, h_cy;
      logic h_wl, h_last;
      logic [9:0] ea;
      hs = 0; cyc = 0; stalled = 1'b0;
      h_addr = '0; h_tap = '0; h_cx = '0; h_cy = '0; h_wl = 1'b0; h_last = 1'b0;
      @(negedge clk);
      start = 1'b1; mode = 1'b1; addr_ready = 1'b0;
      while (hs < 8100 && cyc < 40000) begin
         @(negedge clk);
         start = 1'b0;
         addr_ready = 1'($urandom_range(0, 1));
         #1;
         if (stalled) begin
            assertions++;
            if ({addr_valid, addr, tap_idx, center_x, center_y, win_last, last} !== {1'b1, h_addr, h_tap, h_cx, h_cy, h_wl, h_last})
               begin failures++; $display("[TB] FAIL bp_stable at %0d: got addr=%0d tap=%0d, required addr=%0d tap=%0d", hs, addr, tap_idx, h_addr, h_tap); end
         end
         if (addr_valid && addr_ready) begin
            ea = 10'(win_addr(hs, 32));
            assertions++;
            if (addr !== ea || tap_idx !== 4'(hs % 9) || last !== (hs == 8099))
               begin failures++; $display("[TB] FAIL bp_seq at %0d: got addr=%0d tap=%0d, required addr=%0d tap=%0d", hs, addr, tap_idx, ea, hs % 9); end
            hs++;
         end
         stalled = addr_valid && !addr_ready;
         h_addr = addr; h_tap = tap_idx; h_cx = center_x; h_cy = center_y; h_wl = win_last; h_last = last;
         cyc++;
      end
      assertions++;
      if (hs != 8100)
         begin failures++; $display("[TB] FAIL bp_timeout: got %0d handshakes, required 8100", hs); end
      @(negedge clk);
      addr_ready = 1'b1;
      #1;
      assertions++;
      if (done !== 1'b1 || addr_valid !== 1'b0)
         begin failures++; $display("[TB] FAIL bp_done: got done=%0b valid=%0b, required 1 0", done, addr_valid); end
   endtask

   task automatic test_abort();
      int hs, cyc;
      logic [9:0] ea;
      hs = 0; cyc = 0;
      @(negedge clk);
      start = 1'b1; mode = 1'b0; addr_ready = 1'b1;
      while (hs < 499 && cyc < 1000) begin
         @(negedge clk);
         start = (hs == 100);
         mode  = 1'b1;
         #1;
         ea = 10'(hs);
         assertions++;
         if (addr !== ea || tap_idx !== 4'd0 || addr_valid !== 1'b1)
            begin failures++; $display("[TB] FAIL abort_seq: got addr=%0d tap=%0d, required addr=%0d tap=0", addr, tap_idx, ea); end
         if (addr_valid && addr_ready) hs++;
         cyc++;
      end
      @(negedge clk);
      start = 1'b0; abort = 1'b1;
      #1;
      assertions++;
      if (addr !== 10'd499 || addr_valid !== 1'b1)
         begin failures++; $display("[TB] FAIL abort_at500: got addr=%0d valid=%0b, required 499 1", addr, addr_valid); end
      @(negedge clk);
      abort = 1'b0;
      #1;
      assertions++;
      if (addr_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || addr !== 10'd0 || center_x !== 5'd0 || center_y !== 5'd0)
         begin failures++; $display("[TB] FAIL abort_idle: got valid=%0b busy=%0b done=%0b addr=%0d", addr_valid, busy, done, addr); end
      @(negedge clk);
      #1;
      assertions++;
      if (done !== 1'b0 || busy !== 1'b0)
         begin failures++; $display("[TB] FAIL abort_nodone: got done=%0b busy=%0b, required 0 0", done, busy); end
      start = 1'b1; mode = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         start = 1'b0;
         #1;
         assertions++;
         if (addr !== 10'(i) || addr_valid !== 1'b1)
            begin failures++; $display("[TB] FAIL abort_restart: got addr=%0d valid=%0b, required %0d 1", addr, addr_valid, i); end
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      #1;
      assertions++;
      if (busy !== 1'b0 || done !== 1'b0)
         begin failures++; $display("[TB] FAIL abort_second: got busy=%0b done=%0b, required 0 0", busy, done); end
   endtask

   task automatic test_small_window();
      int hs, cyc;
      int first9[9];
      logic [3:0] ea;
      first9 = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
      hs = 0; cyc = 0;
      @(negedge clk);
      s_start = 1'b1; s_mode = 1'b1; s_ready = 1'b1;
      while (hs < 27 && cyc < 100) begin
         @(negedge clk);
         s_start = 1'b0;
         #1;
         ea = 4'(win_addr(hs, 5));
         assertions++;
         if (s_valid !== 1'b1 || s_addr !== ea || s_tap !== 4'(hs % 9))
            begin failures++; $display("[TB] FAIL small_addr at %0d: got addr=%0d tap=%0d, required %0d %0d", hs, s_addr, s_tap, ea, hs % 9); end
         assertions++;
         if (s_cx !== 3'(1 + hs / 9) || s_cy !== 3'd1 || s_last !== (hs == 26))
            begin failures++; $display("[TB] FAIL small_centre at %0d: got (%0d,%0d) last=%0b", hs, s_cx, s_cy, s_last); end
         if (hs < 9) begin
            assertions++;
            if (s_addr !== 4'(first9[hs]))
               begin failures++; $display("[TB] FAIL small_first9 at %0d: got %0d, required %0d", hs, s_addr, first9[hs]); end
         end
         if (hs == 26) begin
            assertions++;
            if (s_addr !== 4'd14)
               begin failures++; $display("[TB] FAIL small_final: got %0d, required 14", s_addr); end
         end
         if (s_valid && s_ready) hs++;
         cyc++;
      end
      assertions++;
      if (hs != 27)
         begin failures++; $display("[TB] FAIL small_timeout: got %0d handshakes, required 27", hs); end
      @(negedge clk);
      #1;
      assertions++;
      if (s_done !== 1'b1 || s_valid !== 1'b0)
         begin failures++; $display("[TB] FAIL small_done: got done=%0b valid=%0b, required 1 0", s_done, s_valid); end
   endtask

   initial begin
      assertions = 0;
      failures   = 0;
      rst = 1'b1; start = 1'b0; mode = 1'b0; abort = 1'b0; addr_ready = 1'b0;
      s_start = 1'b0; s_mode = 1'b0; s_abort = 1'b0; s_ready = 1'b0;
      test_reset();
      test_linear();
      test_window();
      test_backpressure();
      test_abort();
      test_small_window();
      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule
